// File: rtl/ram_seq_ctrl.sv
// Block sequencer for the parallel-load Ram: fills a staging buffer from an input
// stream, commits it with a one-cycle ld pulse, then drains the Ram word by word.
module ram_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  ram_ld,
    output logic                  ram_clr,
    output logic [SIZE*WIDTH-1:0] ram_par_in,
    input  logic [SIZE*WIDTH-1:0] ram_par_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  block_done,
    output logic [7:0]            blk_cnt
);
    localparam int IDX_W = $clog2(SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
    logic [SIZE-1:0][WIDTH-1:0] staging_q, staging_d;
    logic [SIZE-1:0][WIDTH-1:0] par_out_words;
    logic [7:0]                 blk_cnt_q, blk_cnt_d;
    logic                       in_hs, out_hs;

    // Handshake-facing flags come straight from the state register.
    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == DRAIN);
    assign ram_ld     = (state_q == LOAD) && !flush && !rst;
    assign ram_clr    = rst | flush;
    assign ram_par_in = staging_q;
    assign blk_cnt    = blk_cnt_q;

    assign par_out_words = ram_par_out;
    assign out_data      = par_out_words[rd_idx_q];

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        staging_d  = staging_q;
        blk_cnt_d  = blk_cnt_q;
        block_done = 1'b0;

        unique case (state_q)
            FILL: begin
                if (in_hs) begin
                    staging_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD: state_d = DRAIN;
            DRAIN: begin
                if (out_hs) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d   = '0;
                        block_done = !rst;
                        blk_cnt_d  = blk_cnt_q + 8'd1;
                        state_d    = FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Flush abandons the block but keeps the staged words and the block count.
        if (flush) begin
            state_d    = FILL;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            staging_d  = staging_q;
            blk_cnt_d  = blk_cnt_q;
            block_done = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            // NOTE: the staging buffer is explicitly reset because it drives the Ram inputs.
            staging_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            staging_q <= staging_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Randomized bench for ram_seq_ctrl: an emulated Ram plus a queue-based model of
// the collect / commit / stream-back behaviour of one block at a time.
module tb_ram_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int SIZE  = 8;

    typedef logic [WIDTH-1:0] blk_t [SIZE];

    logic                  clk, rst, flush, in_valid, in_ready, ram_ld, ram_clr;
    logic                  out_valid, out_ready, block_done;
    logic [WIDTH-1:0]      in_data, out_data;
    logic [SIZE*WIDTH-1:0] ram_par_in, ram_par_out;
    logic [7:0]            blk_cnt;
    logic [SIZE-1:0][WIDTH-1:0] ram_mem;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;

    // Reference model: words collected, words waiting to stream out, pending commit.
    logic [WIDTH-1:0] fill_q[$], drain_q[$], blk_words[$], got_q[$];
    bit ld_pending = 0;
    int exp_blk = 0;
    int mdl_done = 0;
    int ld_seen = 0, done_seen = 0;
    int acc_cyc = 0, ld_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;

    ram_seq_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ram_ld(ram_ld), .ram_clr(ram_clr),
        .ram_par_in(ram_par_in), .ram_par_out(ram_par_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .block_done(block_done), .blk_cnt(blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Emulated Ram: synchronous clear has priority over parallel load.
    always @(posedge clk) begin
        if (ram_clr) ram_mem <= '0;
        else if (ram_ld) ram_mem <= ram_par_in;
    end
    assign ram_par_out = ram_mem;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // One clock cycle: drive at negedge, compare before posedge, advance model after it.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy,
                        input logic fl, input logic r, output logic ih, output logic oh);
        logic e_in_ready, e_out_valid, e_ld, e_done, e_clr;
        in_valid = v; in_data = d; out_ready = rdy; flush = fl; rst = r;
        #1;
        e_in_ready  = !ld_pending && drain_q.size() == 0;
        e_out_valid = drain_q.size() != 0;
        e_ld        = ld_pending && !fl && !r;
        e_done      = e_out_valid && rdy && drain_q.size() == 1 && !fl && !r;
        e_clr       = r | fl;
        chk_cnt++; if (in_ready !== e_in_ready) $display("FAIL in_ready cyc %0d: got %b want %b", cyc, in_ready, e_in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== e_out_valid) $display("FAIL out_valid cyc %0d: got %b want %b", cyc, out_valid, e_out_valid); else pass_cnt++;
        chk_cnt++; if (ram_ld !== e_ld) $display("FAIL ram_ld cyc %0d: got %b want %b", cyc, ram_ld, e_ld); else pass_cnt++;
        chk_cnt++; if (ram_clr !== e_clr) $display("FAIL ram_clr cyc %0d: got %b want %b", cyc, ram_clr, e_clr); else pass_cnt++;
        chk_cnt++; if (block_done !== e_done) $display("FAIL block_done cyc %0d: got %b want %b", cyc, block_done, e_done); else pass_cnt++;
        chk_cnt++; if (blk_cnt !== 8'(exp_blk)) $display("FAIL blk_cnt cyc %0d: got %0d want %0d", cyc, blk_cnt, 8'(exp_blk)); else pass_cnt++;
        if (e_out_valid) begin
            chk_cnt++; if (out_data !== drain_q[0]) $display("FAIL out_data cyc %0d: got %h want %h", cyc, out_data, drain_q[0]); else pass_cnt++;
        end
        if (ram_ld === 1'b1) begin ld_seen++; ld_cyc = cyc; end
        if (block_done === 1'b1) done_seen++;
        ih = v && e_in_ready && !fl && !r;
        oh = rdy && e_out_valid && !fl && !r;
        if (oh) begin
            got_q.push_back(out_data);
            if (got_q.size() == 1) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
        @(posedge clk);
        if (r) begin
            fill_q.delete(); drain_q.delete(); ld_pending = 0; exp_blk = 0;
        end else if (fl) begin
            fill_q.delete(); drain_q.delete(); ld_pending = 0;
        end else if (ld_pending) begin
            ld_pending = 0; drain_q = blk_words;
        end else if (drain_q.size() != 0) begin
            if (oh) begin
                void'(drain_q.pop_front());
                if (drain_q.size() == 0) begin exp_blk = (exp_blk + 1) % 256; mdl_done++; end
            end
        end else if (ih) begin
            fill_q.push_back(d);
            if (fill_q.size() == SIZE) begin
                blk_words = fill_q; fill_q.delete(); ld_pending = 1; acc_cyc = cyc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic ih, oh;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, ih, oh);
    endtask

    task automatic feed(input blk_t w, input int n);
        logic ih, oh;
        int tries;
        for (int i = 0; i < n; i++) begin
            tries = 0; ih = 1'b0;
            while (!ih && tries < 20) begin step(1'b1, w[i], 1'b0, 1'b0, 1'b0, ih, oh); tries++; end
            chk_cnt++; if (!ih) $display("FAIL feed_accept: got no accept want accept of word %0d", i); else pass_cnt++;
        end
    endtask

    task automatic drain(input int n);
        logic ih, oh;
        int outs = 0;
        for (int c = 0; c < 40 && outs < n; c++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, ih, oh);
            if (oh) outs++;
        end
        chk_cnt++; if (outs != n) $display("FAIL drain_count: got %0d want %0d", outs, n); else pass_cnt++;
    endtask

    // v_mode: 0 always valid, 1 toggling (junk offered outside FILL), 2 random.
    // r_mode: 0 always ready, 1 three-cycle stall after 3 words, 2 random.
    task automatic run_block(input blk_t w, input int v_mode, input int r_mode);
        logic ih, oh, v_b, rdy_b;
        logic [WIDTH-1:0] d;
        int idx = 0, outs = 0, stall = 0, start = mdl_done, ld0 = ld_seen;
        bit same;
        got_q.delete();
        for (int c = 0; c < 400 && mdl_done == start; c++) begin
            v_b = (v_mode == 0) ? (idx < SIZE) : (v_mode == 1) ? (c % 2 == 0)
                  : (idx < SIZE && $urandom_range(0, 1) == 1);
            d = (idx < SIZE) ? w[idx] : WIDTH'($urandom);
            rdy_b = 1'b1;
            if (r_mode == 1 && outs == 3 && stall < 3) begin rdy_b = 1'b0; stall++; end
            if (r_mode == 2) rdy_b = ($urandom_range(0, 3) != 0);
            step(v_b, d, rdy_b, 1'b0, 1'b0, ih, oh);
            if (ih) idx++;
            if (oh) outs++;
        end
        chk_cnt++; if (mdl_done == start) $display("FAIL block_timeout: got incomplete want complete"); else pass_cnt++;
        same = (got_q.size() == SIZE);
        for (int i = 0; i < SIZE && same; i++) same = (got_q[i] === w[i]);
        chk_cnt++; if (!same) $display("FAIL block_order: got %0d words (first %h) want %h..%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, w[0], w[SIZE-1]); else pass_cnt++;
        chk_cnt++; if (ld_seen - ld0 != 1) $display("FAIL ld_pulses: got %0d want 1", ld_seen - ld0); else pass_cnt++;
    endtask

    task automatic test_reset();
        logic ih, oh;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (ram_ld !== 1'b0) $display("FAIL rst_ram_ld: got %b want 0", ram_ld); else pass_cnt++;
        chk_cnt++; if (block_done !== 1'b0) $display("FAIL rst_block_done: got %b want 0", block_done); else pass_cnt++;
        chk_cnt++; if (blk_cnt !== 8'd0) $display("FAIL rst_blk_cnt: got %0d want 0", blk_cnt); else pass_cnt++;
        chk_cnt++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else pass_cnt++;
        chk_cnt++; if (ram_par_in !== '0) $display("FAIL rst_par_in: got %h want 0", ram_par_in); else pass_cnt++;
        step(1'b1, 16'hdead, 1'b1, 1'b0, 1'b1, ih, oh);
    endtask

    task automatic test_basic();
        blk_t w;
        int d0 = done_seen;
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'(16'h1000 + i);
        run_block(w, 0, 0);
        chk_cnt++; if (ld_cyc != acc_cyc + 1) $display("FAIL basic_ld_latency: got %0d want %0d", ld_cyc - acc_cyc, 1); else pass_cnt++;
        chk_cnt++; if (first_out_cyc != acc_cyc + 2) $display("FAIL basic_first_out: got %0d want %0d", first_out_cyc - acc_cyc, 2); else pass_cnt++;
        chk_cnt++; if (last_out_cyc != acc_cyc + 1 + SIZE) $display("FAIL basic_last_out: got %0d want %0d", last_out_cyc - acc_cyc, 1 + SIZE); else pass_cnt++;
        chk_cnt++; if (done_seen - d0 != 1) $display("FAIL basic_done_pulses: got %0d want 1", done_seen - d0); else pass_cnt++;
        chk_cnt++; if (blk_cnt !== 8'd1) $display("FAIL basic_blk_cnt: got %0d want 1", blk_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        blk_t w;
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom);
        run_block(w, 1, 1);
        chk_cnt++; if (blk_cnt !== 8'(exp_blk)) $display("FAIL bp_blk_cnt: got %0d want %0d", blk_cnt, exp_blk); else pass_cnt++;
    endtask

    task automatic test_flush_fill();
        blk_t w;
        logic ih, oh;
        int ld0 = ld_seen;
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom);
        feed(w, 5);
        step(1'b1, 16'hbeef, 1'b1, 1'b1, 1'b0, ih, oh);
        idle(3);
        chk_cnt++; if (ld_seen != ld0) $display("FAIL flush_fill_no_ld: got %0d want 0", ld_seen - ld0); else pass_cnt++;
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'(16'hA000 + i);
        run_block(w, 0, 0);
        // Flush landing on the LOAD cycle must suppress the commit.
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom);
        ld0 = ld_seen;
        feed(w, SIZE);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, ih, oh);
        idle(2);
        chk_cnt++; if (ld_seen != ld0) $display("FAIL flush_load_no_ld: got %0d want 0", ld_seen - ld0); else pass_cnt++;
    endtask

    task automatic test_flush_drain();
        blk_t w;
        logic ih, oh;
        int d0 = done_seen;
        int cnt0 = exp_blk;
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom);
        feed(w, SIZE); idle(1); drain(3);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, ih, oh);
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_drain_out_valid: got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_drain_in_ready: got %b want 1", in_ready); else pass_cnt++;
        // Flush coinciding with the final output handshake.
        feed(w, SIZE); idle(1); drain(SIZE - 1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, ih, oh);
        idle(1);
        chk_cnt++; if (done_seen != d0) $display("FAIL flush_drain_done: got %0d want 0", done_seen - d0); else pass_cnt++;
        chk_cnt++; if (blk_cnt !== 8'(cnt0)) $display("FAIL flush_drain_blk_cnt: got %0d want %0d", blk_cnt, cnt0); else pass_cnt++;
    endtask

    task automatic test_reset_drain();
        blk_t w;
        logic ih, oh;
        for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom) | 16'h0001;
        feed(w, SIZE); idle(1); drain(3);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, ih, oh);
        rst = 1'b0; out_ready = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rd_in_ready: got %b want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rd_out_valid: got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (ram_ld !== 1'b0 || block_done !== 1'b0) $display("FAIL rd_ld_done: got %b%b want 00", ram_ld, block_done); else pass_cnt++;
        chk_cnt++; if (blk_cnt !== 8'd0) $display("FAIL rd_blk_cnt: got %0d want 0", blk_cnt); else pass_cnt++;
        chk_cnt++; if (out_data !== '0) $display("FAIL rd_out_data: got %h want 0", out_data); else pass_cnt++;
        chk_cnt++; if (ram_par_out !== '0) $display("FAIL rd_ram_contents: got %h want 0", ram_par_out); else pass_cnt++;
        chk_cnt++; if (ram_par_in !== '0) $display("FAIL rd_staging: got %h want 0", ram_par_in); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        blk_t w;
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom);
            run_block(w, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_wrap();
        blk_t w;
        logic ih, oh;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, ih, oh);
        for (int b = 1; b <= 256; b++) begin
            for (int i = 0; i < SIZE; i++) w[i] = WIDTH'($urandom);
            run_block(w, 0, 0);
            if (b == 255) begin
                chk_cnt++; if (blk_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", blk_cnt); else pass_cnt++;
            end
        end
        chk_cnt++; if (blk_cnt !== 8'd0) $display("FAIL wrap_0: got %0d want 0", blk_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_fill();
        test_flush_drain();
        test_reset_drain();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
